// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and small decode helpers.
package y86_pkg;

    // 4-bit register identifier; 15 means "no register".
    typedef logic [3:0] reg_id_t;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register IDs with special meaning
    localparam reg_id_t RRSP  = 4'h4;
    localparam reg_id_t RNONE = 4'hF;

    // True when the ID names a real architectural register.
    function automatic logic is_real_reg(input reg_id_t id);
        return id != RNONE;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 program register file: NREG x W registers, two combinational read
// ports that return 0 for RNONE, two write ports (M beats E on the same ID),
// asynchronous active-low clear.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  reg_id_t      src_a,
    input  reg_id_t      src_b,
    output logic [W-1:0] val_a,
    output logic [W-1:0] val_b,
    input  reg_id_t      dst_e,
    input  logic [W-1:0] val_e,
    input  reg_id_t      dst_m,
    input  logic [W-1:0] val_m
);

    // Read view of all 16 IDs; slots past the last register (RNONE) read as 0.
    logic [W-1:0] rd_vec [0:15];

    logic we_e;
    logic we_m;

    assign we_e = wr_en && is_real_reg(dst_e);
    assign we_m = wr_en && is_real_reg(dst_m);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg
            if (gi < NREG) begin : g_real
                logic [W-1:0] q_reg;

                // One register: cleared by reset, M write has priority over E write.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (we_m && (dst_m == 4'(gi))) begin
                        q_reg <= val_m;
                    end else if (we_e && (dst_e == 4'(gi))) begin
                        q_reg <= val_e;
                    end
                end

                assign rd_vec[gi] = q_reg;
            end else begin : g_none
                assign rd_vec[gi] = '0;
            end
        end
    endgenerate

    // Reads see the pre-edge contents; no bypass from the write data.
    assign val_a = rd_vec[src_a];
    assign val_b = rd_vec[src_b];

endmodule

// File: rtl/decode_writeback.sv
// Decode and write-back stage of the sequential Y86-64 processor: turns
// icode/rA/rB/cnd into register IDs, reads valA/valB, commits valE/valM.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   icode,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic         cnd,
    input  logic [W-1:0] valE,
    input  logic [W-1:0] valM,
    input  logic         wb_en,
    output logic [3:0]   srcA,
    output logic [3:0]   srcB,
    output logic [3:0]   dstE,
    output logic [3:0]   dstM,
    output logic [W-1:0] valA,
    output logic [W-1:0] valB
);

    // Register ID decode; unknown codes (C-F) leave every ID at RNONE so they never write.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            IRRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            IIRMOVQ: begin
                dstE = rB;
            end
            IRMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            IMRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            IOPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            ICALL: begin
                srcB = RRSP;
                dstE = RRSP;
            end
            IRET: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
            end
            IPUSHQ: begin
                srcA = rA;
                srcB = RRSP;
                dstE = RRSP;
            end
            IPOPQ: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
                dstM = rA;
            end
            default: begin
            end
        endcase
    end

    y86_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wb_en),
        .src_a (srcA),
        .src_b (srcB),
        .val_a (valA),
        .val_b (valB),
        .dst_e (dstE),
        .val_e (valE),
        .dst_m (dstM),
        .val_m (valM)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: stimulus pushes the expected decode
// and read values into a queue, a negedge monitor pops and compares them.
module tb_decode_writeback;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic        cnd;
    logic [63:0] valE, valM;
    logic        wb_en;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB;

    always #5 clk = ~clk;

    decode_writeback #(.NREG(15), .W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .valE  (valE),
        .valM  (valM),
        .wb_en (wb_en),
        .srcA  (srcA),
        .srcB  (srcB),
        .dstE  (dstE),
        .dstM  (dstM),
        .valA  (valA),
        .valB  (valB)
    );

    typedef struct {
        logic [3:0]  sa, sb, de, dm;
        logic [63:0] va, vb;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    logic [63:0] model [0:14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [3:0] id);
        return (id == 4'd15) ? 64'd0 : model[id];
    endfunction

    // Reference decode built directly from the instruction-set register usage rules.
    function automatic exp_t ref_decode(input logic [3:0] ic, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic c);
        exp_t e;
        e.sa = 4'd15; e.sb = 4'd15; e.de = 4'd15; e.dm = 4'd15;
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) e.sa = ra;
        else if (ic inside {4'h9, 4'hB})        e.sa = 4'd4;
        if (ic inside {4'h4, 4'h5, 4'h6})       e.sb = rb;
        else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) e.sb = 4'd4;
        if (ic inside {4'h3, 4'h6} || (ic == 4'h2 && c)) e.de = rb;
        else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB})     e.de = 4'd4;
        if (ic inside {4'h5, 4'hB}) e.dm = ra;
        e.va = model_read(e.sa);
        e.vb = model_read(e.sb);
        return e;
    endfunction

    // One instruction: drive after the rising edge, queue the expectation, then
    // apply the commit the coming edge will perform (M written last so it wins).
    task automatic step(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm,
                        input logic en);
        exp_t e;
        @(posedge clk);
        #1;
        icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; wb_en = en;
        e = ref_decode(ic, ra, rb, c);
        exp_q.push_back(e);
        if (en) begin
            if (e.de != 4'd15) model[e.de] = ve;
            if (e.dm != 4'd15) model[e.dm] = vm;
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                chk("srcA", 64'(srcA), 64'(e.sa));
                chk("srcB", 64'(srcB), 64'(e.sb));
                chk("dstE", 64'(dstE), 64'(e.de));
                chk("dstM", 64'(dstM), 64'(e.dm));
                chk("valA", valA, e.va);
                chk("valB", valB, e.vb);
                $display("txn %0d icode=%h rA=%h rB=%h cnd=%b wb=%b -> srcA=%h srcB=%h dstE=%h dstM=%h valA=%h valB=%h",
                         n_txn, icode, rA, rB, cnd, wb_en, srcA, srcB, dstE, dstM, valA, valB);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        icode = 4'h6; rA = 4'h0; rB = 4'h1; cnd = 1'b0;
        valE = 64'd0; valM = 64'd0; wb_en = 1'b0;
        for (int i = 0; i < 15; i++) model[i] = 64'd0;

        // Reset state: registers read as zero, decode still live.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valA", valA, 64'd0);
        chk("reset_valB", valB, 64'd0);
        chk("reset_srcA", 64'(srcA), 64'd0);
        rst_n = 1'b1;

        // irmovq then read back through OPq
        step(4'h3, 4'hF, 4'h4, 1'b0, 64'd7, 64'd0, 1'b1);
        step(4'h6, 4'h4, 4'h6, 1'b0, 64'd0, 64'd0, 1'b0);
        // cmov gated off, then on
        step(4'h2, 4'h4, 4'h6, 1'b0, 64'd7, 64'd0, 1'b1);
        step(4'h6, 4'h6, 4'h6, 1'b0, 64'd0, 64'd0, 1'b0);
        step(4'h2, 4'h4, 4'h6, 1'b1, 64'd7, 64'd0, 1'b1);
        step(4'h6, 4'h6, 4'h6, 1'b0, 64'd0, 64'd0, 1'b0);
        // popq %rsp: valM wins over valE
        step(4'hB, 4'h4, 4'hF, 1'b0, model[4] + 64'd8, 64'h1234, 1'b1);
        step(4'h6, 4'h4, 4'h4, 1'b0, 64'd0, 64'd0, 1'b0);
        // Commit suppression: wb_en low, halt, invalid code
        step(4'h3, 4'hF, 4'h1, 1'b0, 64'd9, 64'd0, 1'b0);
        step(4'h0, 4'h1, 4'h1, 1'b1, 64'd9, 64'd9, 1'b1);
        step(4'hE, 4'h1, 4'h1, 1'b1, 64'd9, 64'd9, 1'b1);
        step(4'h6, 4'h1, 4'h1, 1'b0, 64'd0, 64'd0, 1'b0);
        // Read during write: old value before the edge, new one after
        step(4'h3, 4'hF, 4'h2, 1'b0, 64'd3, 64'd0, 1'b1);
        step(4'h6, 4'h2, 4'h2, 1'b0, 64'd10, 64'd0, 1'b1);
        step(4'h6, 4'h2, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
        // Mid-run reset clears immediately and blocks the in-flight write
        step(4'h3, 4'hF, 4'h0, 1'b0, 64'd5, 64'd0, 1'b1);
        step(4'h6, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        icode = 4'h6; rA = 4'h0; rB = 4'h0; valE = 64'd99; wb_en = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreset_valA", valA, 64'd0);
        chk("midreset_valB", valB, 64'd0);
        for (int i = 0; i < 15; i++) model[i] = 64'd0;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        rst_n = 1'b1;
        step(4'h6, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);

        // Randomized instruction stream against the reference model
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 7) != 0));
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Decode and write-back stage of the sequential Y86-64 processor, directly downstream of fetch. It turns the fetched `icode`/`rA`/`rB` into register-file source and destination IDs and reads `valA`/`valB` combinationally. It holds the fifteen 64-bit program registers and commits `valE`/`valM` at the clock edge that closes the instruction.

## Interface
- `NREG`, 15: number of architectural registers (IDs 0–14); ID 15 is RNONE.
- `W`, 64: data width.
- `clk` in 1: single clock; register writes occur on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `icode` in 4: instruction code from fetch.
- `rA` in 4: register A field from fetch.
- `rB` in 4: register B field from fetch.
- `cnd` in 1: condition result from execute; gates the cmovXX write.
- `valE` in 64: ALU result from execute.
- `valM` in 64: load data from memory stage.
- `wb_en` in 1: commit enable; low for halt, invalid instruction or bad address.
- `srcA` out 4: decoded source A ID.
- `srcB` out 4: decoded source B ID.
- `dstE` out 4: decoded E destination ID, after the `cnd` gate.
- `dstM` out 4: decoded M destination ID.
- `valA` out 64: contents of `srcA`, or 0 when RNONE.
- `valB` out 64: contents of `srcB`, or 0 when RNONE.

## Operation
- Register ID decode (RSP = 4, RNONE = 15):
  - `srcA`: `rA` for cmovXX (2), rmmovq (4), OPq (6), pushq (A); RSP for ret (9) and popq (B); otherwise RNONE.
  - `srcB`: `rB` for rmmovq, mrmovq (5), OPq; RSP for call (8), ret, pushq, popq; otherwise RNONE.
  - `dstE`: `rB` for irmovq (3) and OPq; `rB` for cmovXX only when `cnd`=1, else RNONE; RSP for call, ret, pushq, popq; otherwise RNONE.
  - `dstM`: `rA` for mrmovq and popq; otherwise RNONE.
- Reads are combinational from the register array.
  - A read of RNONE returns 0.
  - A read of the register being written this cycle returns the pre-edge value.
- Write-back happens on the rising edge of `clk` when `wb_en`=1 and `rst_n`=1.
  - `regs[dstE] <= valE` if `dstE` ≠ RNONE.
  - `regs[dstM] <= valM` if `dstM` ≠ RNONE.
  - If `dstE` = `dstM` ≠ RNONE (popq %rsp), `valM` wins.
- Codes C–F decode to all-RNONE outputs. They cause no writes, regardless of `wb_en`.
- The `rA`/`rB` fields of icodes that do not use them are ignored.

## Timing
- Reset: while `rst_n`=0, all 15 registers are forced to 0 immediately, independent of `clk`.
  - The decode outputs stay purely combinational.
  - A `clk` edge while in reset performs no write.
  - Reset asserted mid-program discards the in-flight write.
  - After deassertion, the first write takes effect on the next rising edge.
- Latency: decode IDs and `valA`/`valB` are zero-cycle combinational paths from `icode`/`rA`/`rB`/`cnd`. A committed write is visible on `valA`/`valB` one edge later.
- No combinational path from `valE`/`valM` to `valA`/`valB`. Internal forwarding is forbidden.
- `cnd` affects only `dstE`.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ.
  - register constants: RRSP = 4, RNONE = 15.
  - a 4-bit `reg_id_t` type.
- One sub-module, `y86_regfile`, implements the 15×64 array:
  - two combinational read ports returning 0 for RNONE;
  - two write ports, with the M port having priority;
  - asynchronous active-low clear.
- `decode_writeback` contains the ID decode logic and instantiates `y86_regfile`.

## Test plan
- Reset: drive `rst_n`=0 mid-run after writing `%rax`=5, with `icode`=6, `rA`=0, `rB`=0. Required: `valA`=`valB`=0 immediately, without waiting for a clock edge.
- irmovq write then read:
  - cycle 1: `icode`=3, `rB`=4, `valE`=7, `wb_en`=1;
  - next cycle: `icode`=6, `rA`=4, `rB`=6 (%rsi=0).
  - Required: `srcA`=4, `valA`=7, `srcB`=6, `valB`=0, `dstE`=6.
- cmov gating:
  - `icode`=2, `rA`=4, `rB`=6, `cnd`=0, `valE`=7. Required: `dstE`=15 and %rsi unchanged after the edge.
  - Same stimulus with `cnd`=1. Required: %rsi=7.
- popq %rsp: `icode`=B, `rA`=4, `valE`=%rsp+8, `valM`=0x1234. Required: `srcA`=`srcB`=4, `dstE`=`dstM`=4, %rsp=0x1234 after the edge.
- Commit suppression: `icode`=3, `rB`=1, `valE`=9, `wb_en`=0. Required: %rcx unchanged. Repeat with `icode`=0 (halt) and `icode`=E (invalid). Required: all IDs 15 and no write.
- Read-during-write: `icode`=6, `rA`=`rB`=2 with %rdx=3, `valE`=10. Required: `valA`=`valB`=3 before the edge and 10 after it.
